// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative MULT/MULTU/DIV/DIVU unit for the EX stage.
// Shift-add multiply (MUL_BITS per cycle) and restoring divide (DIV_BITS per cycle).
// Result is packed {HI,LO}: product for mul, {remainder,quotient} for div.
// Optional feature macro MDU_EARLY_OUT_EN: a multiply leaves CALC as soon as the
// unconsumed multiplier bits are all zero. Division is unaffected.
module muldiv_unit #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned MUL_BITS = 2,
  parameter int unsigned DIV_BITS = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [1:0]           op,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic                 cancel,
  output logic                 busy,
  output logic                 stall,
  output logic                 done,
  output logic                 div_zero,
  output logic [2*WIDTH-1:0]   result
);

  localparam int unsigned MulIters = WIDTH / MUL_BITS;
  localparam int unsigned DivIters = WIDTH / DIV_BITS;
  localparam int unsigned CntW     = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {StIdle, StCalc, StFix, StDone} state_e;

  state_e               state_q, state_d;
  logic [1:0]           op_q, op_d;
  logic                 sign_a_q, sign_a_d;
  logic                 sign_b_q, sign_b_d;
  logic                 dz_q, dz_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  // acc: mul product / div {remainder, dividend->quotient}
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  // opa: shifted multiplicand (mul only); opb: multiplier (mul) or divisor (div)
  logic [2*WIDTH-1:0]   opa_q, opa_d;
  logic [WIDTH-1:0]     opb_q, opb_d;
  logic [2*WIDTH-1:0]   result_q, result_d;
  logic                 div_zero_q, div_zero_d;

  logic                 sign_a_in, sign_b_in;
  logic [WIDTH-1:0]     mag_a, mag_b;
  logic                 is_dz;

  logic [2*WIDTH-1:0]   mul_acc, mul_opa;
  logic [WIDTH-1:0]     mul_opb;
  logic [WIDTH-1:0]     div_rem, div_quo;
  logic [WIDTH:0]       div_trial;
  logic                 early_out;

  // Operand magnitudes; the magnitude of MIN is 2^(WIDTH-1), still exact as unsigned.
  assign sign_a_in = op[0] & a[WIDTH-1];
  assign sign_b_in = op[0] & b[WIDTH-1];
  assign mag_a     = sign_a_in ? -a : a;
  assign mag_b     = sign_b_in ? -b : b;
  assign is_dz     = op[1] & (b == '0);

  // One CALC step of shift-add multiply, MUL_BITS multiplier bits retired.
  always_comb begin
    mul_acc = acc_q;
    mul_opa = opa_q;
    mul_opb = opb_q;
    for (int i = 0; i < int'(MUL_BITS); i++) begin
      if (mul_opb[0]) begin
        mul_acc = mul_acc + mul_opa;
      end
      mul_opa = mul_opa << 1;
      mul_opb = mul_opb >> 1;
    end
  end

  // One CALC step of restoring divide, DIV_BITS quotient bits produced.
  always_comb begin
    div_rem   = acc_q[2*WIDTH-1:WIDTH];
    div_quo   = acc_q[WIDTH-1:0];
    div_trial = '0;
    for (int i = 0; i < int'(DIV_BITS); i++) begin
      div_trial = {div_rem, div_quo[WIDTH-1]} - {1'b0, opb_q};
      if (div_trial[WIDTH]) begin
        // Trial went negative: keep the shifted remainder, quotient bit 0.
        div_rem = {div_rem[WIDTH-2:0], div_quo[WIDTH-1]};
        div_quo = {div_quo[WIDTH-2:0], 1'b0};
      end else begin
        div_rem = div_trial[WIDTH-1:0];
        div_quo = {div_quo[WIDTH-2:0], 1'b1};
      end
    end
  end

`ifdef MDU_EARLY_OUT_EN
  // Remaining multiplier bits all zero after this step: product is final.
  assign early_out = ~op_q[1] & (mul_opb == '0);
`else
  assign early_out = 1'b0;
`endif

  // Next-state and datapath updates.
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    sign_a_d   = sign_a_q;
    sign_b_d   = sign_b_q;
    dz_d       = dz_q;
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    opa_d      = opa_q;
    opb_d      = opb_q;
    result_d   = result_q;
    div_zero_d = div_zero_q;

    unique case (state_q)
      StIdle: begin
        if (start && !cancel) begin
          op_d     = op;
          sign_a_d = sign_a_in;
          sign_b_d = sign_b_in;
          dz_d     = is_dz;
          opb_d    = mag_b;
          if (op[1]) begin
            cnt_d = CntW'(DivIters - 1);
            acc_d = {{WIDTH{1'b0}}, mag_a};
            opa_d = '0;
          end else begin
            cnt_d = CntW'(MulIters - 1);
            acc_d = '0;
            opa_d = {{WIDTH{1'b0}}, mag_a};
          end
          if (is_dz) begin
            // Divide by zero skips CALC but still spends the FIX cycle (latency 2).
            acc_d   = {a, {WIDTH{1'b1}}};
            state_d = StFix;
          end else begin
            state_d = StCalc;
          end
        end
      end
      StCalc: begin
        if (cancel) begin
          state_d = StIdle;
        end else begin
          if (op_q[1]) begin
            acc_d = {div_rem, div_quo};
          end else begin
            acc_d = mul_acc;
            opa_d = mul_opa;
            opb_d = mul_opb;
          end
          cnt_d = cnt_q - 1'b1;
          if (cnt_q == '0 || early_out) begin
            state_d = StFix;
          end
        end
      end
      StFix: begin
        if (cancel) begin
          state_d = StIdle;
        end else begin
          state_d = StDone;
          if (!dz_q) begin
            if (!op_q[1]) begin
              if (sign_a_q ^ sign_b_q) begin
                acc_d = -acc_q;
              end
            end else begin
              if (sign_a_q ^ sign_b_q) begin
                acc_d[WIDTH-1:0] = -acc_q[WIDTH-1:0];
              end
              if (sign_a_q) begin
                acc_d[2*WIDTH-1:WIDTH] = -acc_q[2*WIDTH-1:WIDTH];
              end
            end
          end
        end
      end
      StDone: begin
        state_d = StIdle;
        if (!cancel) begin
          result_d   = acc_q;
          div_zero_d = dz_q;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StIdle;
      op_q       <= '0;
      sign_a_q   <= 1'b0;
      sign_b_q   <= 1'b0;
      dz_q       <= 1'b0;
      cnt_q      <= '0;
      acc_q      <= '0;
      opa_q      <= '0;
      opb_q      <= '0;
      result_q   <= '0;
      div_zero_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      sign_a_q   <= sign_a_d;
      sign_b_q   <= sign_b_d;
      dz_q       <= dz_d;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      opa_q      <= opa_d;
      opb_q      <= opb_d;
      result_q   <= result_d;
      div_zero_q <= div_zero_d;
    end
  end

  // Outputs: the DONE cycle forwards the fresh result so it is valid alongside done.
  always_comb begin
    busy     = (state_q != StIdle);
    done     = (state_q == StDone) & ~cancel;
    stall    = (start & (state_q == StIdle) & ~cancel) | (busy & ~done);
    result   = done ? acc_q : result_q;
    div_zero = done ? dz_q : div_zero_q;
  end

endmodule
